// File: rtl/ex_muldiv_pkg.sv
// Shared EX-stage definitions: aluop codes, widths, enable levels, divider state encoding.
package ex_muldiv_pkg;

    localparam int WORD_W = 32;

    typedef logic [7:0]        aluop_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam logic  RST_EN    = 1'b1;
    localparam logic  WRITE_EN  = 1'b1;
    localparam logic  WRITE_DIS = 1'b0;
    localparam word_t ZERO_WORD = '0;

    localparam aluop_t ALU_NOP   = 8'b0000_0000;
    localparam aluop_t ALU_MTHI  = 8'b0001_0001;
    localparam aluop_t ALU_MTLO  = 8'b0001_0011;
    localparam aluop_t ALU_MULT  = 8'b0001_1000;
    localparam aluop_t ALU_MULTU = 8'b0001_1001;
    localparam aluop_t ALU_DIV   = 8'b0001_1010;
    localparam aluop_t ALU_DIVU  = 8'b0001_1011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_BUSY = 2'd2,
        DIV_END  = 2'd3
    } div_state_t;

    function automatic word_t abs_word(input logic is_signed, input word_t v);
        return (is_signed && v[WORD_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage HI/LO unit bus: operands and forwarded HI/LO in, stall and HI/LO write out.
interface ex_muldiv_if;
    import ex_muldiv_pkg::*;

    aluop_t aluop_i;
    word_t  reg1_i;
    word_t  reg2_i;
    word_t  hi_i;
    word_t  lo_i;
    logic   cancel_i;
    logic   stall_o;
    logic   whilo_o;
    word_t  hi_o;
    word_t  lo_o;

    modport master (
        output aluop_i, reg1_i, reg2_i, hi_i, lo_i, cancel_i,
        input  stall_o, whilo_o, hi_o, lo_o
    );

    modport slave (
        input  aluop_i, reg1_i, reg2_i, hi_i, lo_i, cancel_i,
        output stall_o, whilo_o, hi_o, lo_o
    );
endinterface

// File: rtl/ex_muldiv_div.sv
// Restoring divider: 32 cycles busy (1 for divide-by-zero), result held one cycle with ready.
// Caller holds start/operands while busy; cancel drops the divide without producing ready.
module ex_div
    import ex_muldiv_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  logic  signed_div,
    input  word_t opdata1,
    input  word_t opdata2,
    input  logic  cancel,
    output logic  ready,
    output word_t quotient,
    output word_t remainder
);

    div_state_t       state;
    logic [4:0]       count;
    word_t            dvd;
    word_t            dvs;
    word_t            rem;
    logic             neg_q;
    logic             neg_r;
    logic [WORD_W:0]  rem_sh;
    logic [WORD_W:0]  diff;
    word_t            q_next;
    word_t            r_next;

    // dvd shifts quotient bits in from the bottom as dividend bits leave the top.
    always_comb begin
        rem_sh = {rem, dvd[WORD_W-1]};
        diff   = rem_sh - {1'b0, dvs};
        if (!diff[WORD_W]) begin
            r_next = diff[WORD_W-1:0];
            q_next = {dvd[WORD_W-2:0], 1'b1};
        end else begin
            r_next = rem_sh[WORD_W-1:0];
            q_next = {dvd[WORD_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_EN) begin
            state     <= DIV_IDLE;
            count     <= '0;
            dvd       <= ZERO_WORD;
            dvs       <= ZERO_WORD;
            rem       <= ZERO_WORD;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= ZERO_WORD;
            remainder <= ZERO_WORD;
            ready     <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    ready <= 1'b0;
                    if (start) begin
                        if (opdata2 == ZERO_WORD) begin
                            state <= DIV_ZERO;
                        end else begin
                            state <= DIV_BUSY;
                            count <= '0;
                            dvd   <= abs_word(signed_div, opdata1);
                            dvs   <= abs_word(signed_div, opdata2);
                            rem   <= ZERO_WORD;
                            neg_q <= signed_div && (opdata1[WORD_W-1] ^ opdata2[WORD_W-1]);
                            neg_r <= signed_div && opdata1[WORD_W-1];
                        end
                    end
                end
                DIV_ZERO: begin
                    if (cancel) begin
                        state <= DIV_IDLE;
                    end else begin
                        quotient  <= ZERO_WORD;
                        remainder <= ZERO_WORD;
                        ready     <= 1'b1;
                        state     <= DIV_END;
                    end
                end
                DIV_BUSY: begin
                    if (cancel) begin
                        state <= DIV_IDLE;
                    end else begin
                        dvd   <= q_next;
                        rem   <= r_next;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            quotient  <= neg_q ? -q_next : q_next;
                            remainder <= neg_r ? -r_next : r_next;
                            ready     <= 1'b1;
                            state     <= DIV_END;
                        end
                    end
                end
                default: begin
                    ready <= 1'b0;
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage HI/LO unit: MULT/MULTU/MTHI/MTLO same cycle; DIV/DIVU (only with EX_MULDIV_DIV_EN)
// stall upstream 33 cycles (2 for divide-by-zero) and write HI/LO on the cycle stall drops.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);

    logic                  mul_signed;
    logic [DATA_W-1:0]     mul_a;
    logic [DATA_W-1:0]     mul_b;
    logic [2*DATA_W-1:0]   prod_u;
    logic [2*DATA_W-1:0]   prod;
    logic                  div_op;
    logic                  div_ready;
    word_t                 div_q;
    word_t                 div_r;

    // Magnitudes are multiplied unsigned; the product is negated on sign mismatch.
    always_comb begin
        mul_signed = (bus.aluop_i == ALU_MULT);
        mul_a      = abs_word(mul_signed, bus.reg1_i);
        mul_b      = abs_word(mul_signed, bus.reg2_i);
        prod_u     = {{DATA_W{1'b0}}, mul_a} * {{DATA_W{1'b0}}, mul_b};
        prod       = (mul_signed && (bus.reg1_i[DATA_W-1] ^ bus.reg2_i[DATA_W-1])) ? -prod_u : prod_u;
    end

`ifdef EX_MULDIV_DIV_EN
    assign div_op = (bus.aluop_i == ALU_DIV) || (bus.aluop_i == ALU_DIVU);

    ex_div u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (div_op),
        .signed_div (bus.aluop_i == ALU_DIV),
        .opdata1    (bus.reg1_i),
        .opdata2    (bus.reg2_i),
        .cancel     (bus.cancel_i),
        .ready      (div_ready),
        .quotient   (div_q),
        .remainder  (div_r)
    );
`else
    assign div_op    = 1'b0;
    assign div_ready = 1'b0;
    assign div_q     = ZERO_WORD;
    assign div_r     = ZERO_WORD;
`endif

    always_comb begin
        bus.stall_o = 1'b0;
        bus.whilo_o = WRITE_DIS;
        bus.hi_o    = bus.hi_i;
        bus.lo_o    = bus.lo_i;
        if (rst == RST_EN) begin
            bus.hi_o = ZERO_WORD;
            bus.lo_o = ZERO_WORD;
        end else if (div_ready) begin
            // A flush in the result cycle suppresses the HI/LO write.
            if (!bus.cancel_i) begin
                bus.whilo_o = WRITE_EN;
                bus.hi_o    = div_r;
                bus.lo_o    = div_q;
            end
        end else begin
            case (bus.aluop_i)
                ALU_MULT, ALU_MULTU: begin
                    bus.whilo_o = WRITE_EN;
                    bus.hi_o    = prod[2*DATA_W-1:DATA_W];
                    bus.lo_o    = prod[DATA_W-1:0];
                end
                ALU_MTHI: begin
                    bus.whilo_o = WRITE_EN;
                    bus.hi_o    = bus.reg1_i;
                end
                ALU_MTLO: begin
                    bus.whilo_o = WRITE_EN;
                    bus.lo_o    = bus.reg1_i;
                end
                default: bus.stall_o = div_op;
            endcase
        end
    end

endmodule
